chunked_adder: RTL

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder.sv | 109 ++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// and publishes sum/cout/ovf together on the edge that finishes the MSB chunk.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CH_SAFE = (CHUNK >= 1) ? CHUNK : 1;
  localparam int N       = WIDTH / CH_SAFE;
  localparam int CW      = (N > 1) ? $clog2(N) : 1;
  localparam int IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if ((CHUNK < 1) || ((WIDTH % CH_SAFE) != 0)) begin : g_bad_cfg
    $error("chunked_adder: CHUNK must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q, res_d, sum_q;
  logic               carry_q, cout_q, ovf_q;
  logic [CW-1:0]      cnt_q;

  logic [IW-1:0]      base;
  logic [CHUNK-1:0]   a_ch, b_ch, psum;
  logic               c_out, msb_cin, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // One chunk of the ripple; the carry into the top bit falls out as a^b^s there.
  always_comb begin
    base              = IW'(cnt_q * CH_SAFE);
    a_ch              = a_q[base +: CHUNK];
    b_ch              = b_q[base +: CHUNK];
    {c_out, psum}     = {1'b0, a_ch} + {1'b0, b_ch} + (CHUNK+1)'(carry_q);
    msb_cin           = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ psum[CHUNK-1];
    res_d             = res_q;
    res_d[base +: CHUNK] = psum;
    last              = (cnt_q == CW'(N-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          carry_q <= cin ^ sub;
          cnt_q   <= '0;
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= c_out;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            sum_q  <= res_d;
            cout_q <= c_out;
            ovf_q  <= msb_cin ^ c_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
